trap_ctrl: RTL and testbench

Trap and interrupt sequencer sitting between the pipeline's memory stage and the machine-mode CSR file. It arbitrates each retiring instruction's synchronous exception (ecall, illegal instruction, mret) against the three pending machine interrupts (external, timer, software), gated by mstatus.MIE and mie. It issues exactly one single-cycle trap event, in the CSR file's excepttype encoding, together with the faulting PC. It then flushes the pipeline, redirects fetch to the mtvec/mepc target, and holds off further traps until the CSR side effects are visible.

---
 rtl/trap_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Trap and interrupt sequencer between the memory stage and the machine-mode
// CSR file. Arbitrates the retiring instruction's synchronous exception
// against the enabled machine interrupts. Issues one single-cycle trap event
// with the faulting PC, flushes the pipeline, redirects fetch, and then stalls
// for SETTLE_CYCLES so the CSR side effects are visible before the next trap.
//
// Parameters
//   SETTLE_CYCLES    stall cycles after trap entry (1..7)
//   EXT_SYNC_STAGES  synchronizer depth on ext_irq_i (2..3)
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   inst_valid_i                 an instruction retires this cycle
//   inst_addr_i                  PC of the retiring instruction
//   excepttype_i                 0 none, 0x2 illegal, 0x8 ecall, 0xA mret
//   ext_irq_i                    external interrupt (asynchronous level)
//   timer_irq_i, soft_irq_i      timer / software interrupt (clk domain level)
//   mstatus_i, mie_i             interrupt enables
//   mtvec_i, mepc_i              trap vector and return address
//   excepttype_o                 trap event to the CSR file (one cycle)
//   current_inst_addr_o          PC associated with the last trap event
//   flush_o                      flush all pipeline stages
//   new_pc_o                     fetch redirect target while flush_o=1
//   stall_o                      freeze fetch/decode while settling
// ---------------------------------------------------------------------------
module trap_ctrl #(
    parameter int SETTLE_CYCLES   = 1,
    parameter int EXT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] excepttype_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic        soft_irq_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTER  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [31:0] EXC_ILLEGAL = 32'h0000_0002;
    localparam logic [31:0] EXC_ECALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_MRET    = 32'h0000_000A;
    localparam logic [31:0] IRQ_EXT     = 32'h8000_000B;
    localparam logic [31:0] IRQ_TIMER   = 32'h8000_0007;
    localparam logic [31:0] IRQ_SOFT    = 32'h8000_0000;
    localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [2:0]                   r_settle_cnt;
    logic [EXT_SYNC_STAGES-1:0]   r_ext_sync;
    logic [31:0]                  r_code;
    logic [31:0]                  r_inst_addr;
    logic [31:0]                  r_new_pc;

    logic        w_ext_sync;
    logic        w_ext_pend;
    logic        w_soft_pend;
    logic        w_timer_pend;
    logic        w_is_exc;
    logic        w_event;
    logic        w_is_irq;
    logic [31:0] w_code;
    logic [4:0]  w_cause;
    logic [31:0] w_base;
    logic [31:0] w_new_pc;
    logic        w_unused;

    // Only MIE, the three mie enables and the mtvec mode bits matter here.
    assign w_unused = &{1'b0, mstatus_i[31:4], mstatus_i[2:0],
                        mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    // ext_irq_i comes from another clock domain; shift it through a chain of
    // flops and use only the last stage.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ext_sync <= '0;
        else     r_ext_sync <= {r_ext_sync[EXT_SYNC_STAGES-2:0], ext_irq_i};
    end

    assign w_ext_sync   = r_ext_sync[EXT_SYNC_STAGES-1];
    assign w_ext_pend   = w_ext_sync  & mie_i[11] & mstatus_i[3];
    assign w_soft_pend  = soft_irq_i  & mie_i[3]  & mstatus_i[3];
    assign w_timer_pend = timer_irq_i & mie_i[7]  & mstatus_i[3];

    // Unknown exception codes fall through as "none" so interrupts still win.
    assign w_is_exc = (excepttype_i == EXC_ILLEGAL) ||
                      (excepttype_i == EXC_ECALL)   ||
                      (excepttype_i == EXC_MRET);

    // Arbitration: exception > ext > soft > timer.
    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        w_event  = 1'b0;
        w_is_irq = 1'b0;
        w_code   = '0;
        w_cause  = '0;
        if (inst_valid_i) begin
            if (w_is_exc) begin
                w_event = 1'b1;
                w_code  = excepttype_i;
            end else if (w_ext_pend) begin
                w_event  = 1'b1;
                w_is_irq = 1'b1;
                w_code   = IRQ_EXT;
                w_cause  = 5'd11;
            end else if (w_soft_pend) begin
                // Software uses code 0 for the CSR file but cause 3 for vectoring.
                w_event  = 1'b1;
                w_is_irq = 1'b1;
                w_code   = IRQ_SOFT;
                w_cause  = 5'd3;
            end else if (w_timer_pend) begin
                w_event  = 1'b1;
                w_is_irq = 1'b1;
                w_code   = IRQ_TIMER;
                w_cause  = 5'd7;
            end
        end
    end

    assign w_base = {mtvec_i[31:2], 2'b00};

    always_comb begin
        w_new_pc = w_base;
        if (w_code == EXC_MRET)
            w_new_pc = mepc_i;
        else if (w_is_irq && (mtvec_i[1:0] == 2'b01))
            w_new_pc = w_base + {25'd0, w_cause, 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 3'd1 : 3'd0;
        end
    end

    // Capture the winning event on the IDLE->ENTER edge so ENTER drives
    // stable values regardless of what the pipeline presents meanwhile.
    // current_inst_addr_o keeps its last value between traps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code      <= '0;
            r_inst_addr <= '0;
            r_new_pc    <= '0;
        end else if (r_state == S_IDLE && w_event) begin
            r_code      <= w_code;
            r_inst_addr <= inst_addr_i;
            r_new_pc    <= w_new_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        excepttype_o = '0;
        flush_o      = 1'b0;
        new_pc_o     = '0;
        stall_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_event) w_next_state = S_ENTER;
            end
            S_ENTER: begin
                excepttype_o = r_code;
                flush_o      = 1'b1;
                new_pc_o     = r_new_pc;
                w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                stall_o = 1'b1;
                if (r_settle_cnt == SETTLE_LAST) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign current_inst_addr_o = r_inst_addr;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Directed bench for trap_ctrl with default parameters (SETTLE_CYCLES=1,
// EXT_SYNC_STAGES=2). A vector table covers single-instruction arbitration
// and target computation; hand sequences cover synchronizer latency,
// ext priority, MIE gating, trap hold-off and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_addr_i;
    logic [31:0] excepttype_i;
    logic        ext_irq_i;
    logic        timer_irq_i;
    logic        soft_irq_i;
    logic [31:0] mstatus_i;
    logic [31:0] mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    trap_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .inst_valid_i        (inst_valid_i),
        .inst_addr_i         (inst_addr_i),
        .excepttype_i        (excepttype_i),
        .ext_irq_i           (ext_irq_i),
        .timer_irq_i         (timer_irq_i),
        .soft_irq_i          (soft_irq_i),
        .mstatus_i           (mstatus_i),
        .mie_i               (mie_i),
        .mtvec_i             (mtvec_i),
        .mepc_i              (mepc_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .stall_o             (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] exc;
        logic        tmr;
        logic        sft;
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        ev;
        logic [31:0] code;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        inst_valid_i = 1'b0;
        inst_addr_i  = 32'h0;
        excepttype_i = 32'h0;
        ext_irq_i    = 1'b0;
        timer_irq_i  = 1'b0;
        soft_irq_i   = 1'b0;
        mstatus_i    = 32'h8;
        mie_i        = 32'h888;
        mtvec_i      = 32'h400;
        mepc_i       = 32'h0;
    endtask

    // Step until flush_o is seen or the budget runs out; n = cycles taken.
    task automatic wait_flush(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (flush_o) begin
                n = i + 1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_addr;
        int n;
        int pulses;

        //           valid addr          exc    tmr  sft  mstatus mie     mtvec          mepc           ev   code           pc
        vecs[0]  = '{1'b1, 32'h100, 32'h8, 1'b0, 1'b0, 32'h8, 32'h888, 32'h400, 32'h0,   1'b1, 32'h8,         32'h400};
        vecs[1]  = '{1'b1, 32'h104, 32'h2, 1'b0, 1'b0, 32'h8, 32'h888, 32'h403, 32'h0,   1'b1, 32'h2,         32'h400};
        vecs[2]  = '{1'b1, 32'h108, 32'hA, 1'b0, 1'b0, 32'h8, 32'h888, 32'h400, 32'h204, 1'b1, 32'hA,         32'h204};
        vecs[3]  = '{1'b1, 32'h10C, 32'h0, 1'b1, 1'b0, 32'h8, 32'h888, 32'h401, 32'h0,   1'b1, 32'h8000_0007, 32'h41C};
        vecs[4]  = '{1'b1, 32'h110, 32'h0, 1'b1, 1'b1, 32'h8, 32'h888, 32'h400, 32'h0,   1'b1, 32'h8000_0000, 32'h400};
        vecs[5]  = '{1'b1, 32'h114, 32'h5, 1'b1, 1'b0, 32'h8, 32'h888, 32'h401, 32'h0,   1'b1, 32'h8000_0007, 32'h41C};
        vecs[6]  = '{1'b1, 32'h118, 32'h5, 1'b0, 1'b0, 32'h8, 32'h888, 32'h400, 32'h0,   1'b0, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 32'h11C, 32'h0, 1'b1, 1'b0, 32'h0, 32'h888, 32'h400, 32'h0,   1'b0, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 32'h120, 32'h0, 1'b1, 1'b1, 32'h8, 32'h080, 32'h401, 32'h0,   1'b1, 32'h8000_0007, 32'h41C};
        vecs[9]  = '{1'b0, 32'h124, 32'h8, 1'b0, 1'b0, 32'h8, 32'h888, 32'h400, 32'h0,   1'b0, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 32'h128, 32'h8, 1'b1, 1'b0, 32'h8, 32'h888, 32'h401, 32'h0,   1'b1, 32'h8,         32'h400};
        vecs[11] = '{1'b1, 32'h12C, 32'hA, 1'b0, 1'b1, 32'h8, 32'h888, 32'h401, 32'h300, 1'b1, 32'hA,         32'h300};
        vecs[12] = '{1'b1, 32'h130, 32'h0, 1'b0, 1'b1, 32'h8, 32'h008, 32'h801, 32'h0,   1'b1, 32'h8000_0000, 32'h80C};
        vecs[13] = '{1'b1, 32'h134, 32'h0, 1'b0, 1'b1, 32'h8, 32'h000, 32'h401, 32'h0,   1'b0, 32'h0,         32'h0};

        // ---------------- reset state ----------------
        set_idle();
        rst = 1'b1;
        #2;
        check("rst_excepttype", excepttype_o, 32'h0);
        check("rst_cur_addr", current_inst_addr_o, 32'h0);
        check("rst_flush", 32'(flush_o), 32'h0);
        check("rst_new_pc", new_pc_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        step();
        rst = 1'b0;
        step();

        // ---------------- table-driven vectors ----------------
        last_addr = 32'h0;
        for (int i = 0; i < NV; i++) begin
            inst_valid_i = vecs[i].valid;
            inst_addr_i  = vecs[i].addr;
            excepttype_i = vecs[i].exc;
            timer_irq_i  = vecs[i].tmr;
            soft_irq_i   = vecs[i].sft;
            mstatus_i    = vecs[i].mstatus;
            mie_i        = vecs[i].mie;
            mtvec_i      = vecs[i].mtvec;
            mepc_i       = vecs[i].mepc;
            step();
            if (vecs[i].ev) last_addr = vecs[i].addr;
            check($sformatf("v%0d_flush", i), 32'(flush_o), 32'(vecs[i].ev));
            check($sformatf("v%0d_code", i), excepttype_o, vecs[i].code);
            check($sformatf("v%0d_cur_addr", i), current_inst_addr_o, last_addr);
            check($sformatf("v%0d_new_pc", i), new_pc_o, vecs[i].pc);
            set_idle();
            if (vecs[i].ev) begin
                step();
                check($sformatf("v%0d_settle_stall", i), 32'(stall_o), 32'h1);
                check($sformatf("v%0d_settle_flush", i), 32'(flush_o), 32'h0);
                check($sformatf("v%0d_settle_code", i), excepttype_o, 32'h0);
                check($sformatf("v%0d_settle_pc", i), new_pc_o, 32'h0);
                step();
                check($sformatf("v%0d_idle_stall", i), 32'(stall_o), 32'h0);
            end else begin
                check($sformatf("v%0d_stall", i), 32'(stall_o), 32'h0);
            end
        end

        // ---------------- ext synchronizer latency ----------------
        set_idle();
        inst_valid_i = 1'b1;
        inst_addr_i  = 32'h200;
        mie_i        = 32'h800;
        ext_irq_i    = 1'b1;
        wait_flush(10, n);
        check("ext_lat_seen", 32'(flush_o), 32'h1);
        check("ext_lat_cycles", 32'(n), 32'd3);
        check("ext_lat_code", excepttype_o, 32'h8000_000B);
        set_idle();
        repeat (4) step();

        // ---------------- priority ext > soft > timer, then soft ----------------
        mtvec_i   = 32'h401;
        ext_irq_i = 1'b1;
        repeat (3) step();
        check("prio_no_event_without_valid", 32'(flush_o), 32'h0);
        soft_irq_i   = 1'b1;
        timer_irq_i  = 1'b1;
        inst_valid_i = 1'b1;
        inst_addr_i  = 32'h300;
        step();
        check("prio_ext_flush", 32'(flush_o), 32'h1);
        check("prio_ext_code", excepttype_o, 32'h8000_000B);
        check("prio_ext_pc", new_pc_o, 32'h42C);
        check("prio_ext_addr", current_inst_addr_o, 32'h300);
        ext_irq_i = 1'b0;
        wait_flush(8, n);
        check("prio_soft_seen", 32'(flush_o), 32'h1);
        check("prio_spacing", 32'(n), 32'd3);
        check("prio_soft_code", excepttype_o, 32'h8000_0000);
        check("prio_soft_pc", new_pc_o, 32'h40C);
        set_idle();
        repeat (3) step();

        // ---------------- MIE gating ----------------
        mstatus_i    = 32'h0;
        mie_i        = 32'h080;
        timer_irq_i  = 1'b1;
        inst_valid_i = 1'b1;
        inst_addr_i  = 32'h400;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (flush_o || excepttype_o != 32'h0) pulses++;
        end
        check("gate_no_event", 32'(pulses), 32'h0);
        mstatus_i = 32'h8;
        step();
        check("gate_enter_flush", 32'(flush_o), 32'h1);
        check("gate_enter_code", excepttype_o, 32'h8000_0007);
        set_idle();
        repeat (3) step();

        // ---------------- hold-off: ext held, MIE cleared by CSR write ----------------
        mie_i        = 32'h800;
        inst_valid_i = 1'b1;
        inst_addr_i  = 32'h500;
        ext_irq_i    = 1'b1;
        wait_flush(10, n);
        check("hold_first_seen", 32'(flush_o), 32'h1);
        check("hold_first_code", excepttype_o, 32'h8000_000B);
        step();
        mstatus_i = 32'h0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (excepttype_o != 32'h0) pulses++;
            step();
        end
        check("hold_no_second_trap", 32'(pulses), 32'h0);
        set_idle();
        repeat (4) step();

        // ---------------- asynchronous reset mid-ENTER ----------------
        inst_valid_i = 1'b1;
        inst_addr_i  = 32'h600;
        excepttype_i = 32'h8;
        step();
        check("rst_mid_enter_flush_before", 32'(flush_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_code", excepttype_o, 32'h0);
        check("rst_mid_cur_addr", current_inst_addr_o, 32'h0);
        check("rst_mid_flush", 32'(flush_o), 32'h0);
        check("rst_mid_new_pc", new_pc_o, 32'h0);
        check("rst_mid_stall", 32'(stall_o), 32'h0);
        set_idle();
        #3;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (excepttype_o != 32'h0 || flush_o || stall_o) pulses++;
        end
        check("rst_no_partial_trap", 32'(pulses), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
